// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//   Running minimum/maximum tracker for 16-bit unsigned samples. Drives an
//   external 16-bit comparator through cmp_a/cmp_b and uses its gt/lt/eq
//   results. One comparator is shared: each sample after the first takes two
//   compare cycles (against max, then against min).
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   clear         synchronous clear of all tracked state (beats everything
//                 except n_rst)
//   sample_valid  sample_data is valid
//   sample_data   16-bit unsigned sample
//   sample_ready  block accepts a sample this cycle
//   cmp_a/cmp_b   comparator operands
//   cmp_gt/lt/eq  comparator results for (cmp_a, cmp_b), same cycle
//   max_val       largest sample seen (reset 16'h0000)
//   min_val       smallest sample seen (reset 16'hFFFF)
//   count         samples absorbed, saturating at 2^CNT_W-1
//   new_max       one-cycle pulse: max_val updated at previous edge
//   new_min       one-cycle pulse: min_val updated at previous edge
//   cmp_err       sticky: comparator flags not one-hot during a compare cycle
// -----------------------------------------------------------------------------
module minmax_tracker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [15:0]      sample_data,
    output logic             sample_ready,
    output logic [15:0]      cmp_a,
    output logic [15:0]      cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [15:0]      max_val,
    output logic [15:0]      min_val,
    output logic [CNT_W-1:0] count,
    output logic             new_max,
    output logic             new_min,
    output logic             cmp_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP_MAX = 2'd1,
        CMP_MIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      sample_q, sample_d;
    logic [15:0]      max_q, max_d;
    logic [15:0]      min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             new_max_q, new_max_d;
    logic             new_min_q, new_min_d;
    logic             err_q, err_d;

    logic             accept;
    logic             cnt_zero;
    logic [1:0]       n_flags;
    logic             flags_bad;

    // Acceptance only depends on state and clear, never on comparator flags.
    assign accept    = sample_valid && (state_q == IDLE) && !clear;
    assign cnt_zero  = (cnt_q == '0);
    assign n_flags   = 2'(cmp_gt) + 2'(cmp_lt) + 2'(cmp_eq);
    assign flags_bad = (n_flags != 2'd1);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept && !cnt_zero) state_d = CMP_MAX;
                CMP_MAX: state_d = CMP_MIN;
                CMP_MIN: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: combinational from state and registers only
    always_comb begin
        sample_ready = 1'b0;
        cmp_a        = '0;
        cmp_b        = '0;
        unique case (state_q)
            IDLE:    sample_ready = !clear;
            CMP_MAX: begin
                cmp_a = sample_q;
                cmp_b = max_q;
            end
            CMP_MIN: begin
                cmp_a = sample_q;
                cmp_b = min_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sample_d  = sample_q;
        max_d     = max_q;
        min_d     = min_q;
        cnt_d     = cnt_q;
        new_max_d = 1'b0;
        new_min_d = 1'b0;
        err_d     = err_q;
        if (clear) begin
            sample_d = '0;
            max_d    = '0;
            min_d    = '1;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (cnt_zero) begin
                            // First sample seeds both extremes without comparing.
                            max_d     = sample_data;
                            min_d     = sample_data;
                            new_max_d = 1'b1;
                            new_min_d = 1'b1;
                            cnt_d     = CNT_W'(1);
                        end else begin
                            sample_d = sample_data;
                        end
                    end
                end
                CMP_MAX: begin
                    if (cmp_gt) begin
                        max_d     = sample_q;
                        new_max_d = 1'b1;
                    end
                    if (flags_bad) err_d = 1'b1;
                end
                CMP_MIN: begin
                    if (cmp_lt) begin
                        min_d     = sample_q;
                        new_min_d = 1'b1;
                    end
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (flags_bad) err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample_q  <= '0;
            max_q     <= '0;
            min_q     <= '1;
            cnt_q     <= '0;
            new_max_q <= 1'b0;
            new_min_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            max_q     <= max_d;
            min_q     <= min_d;
            cnt_q     <= cnt_d;
            new_max_q <= new_max_d;
            new_min_q <= new_min_d;
            err_q     <= err_d;
        end
    end

    assign max_val = max_q;
    assign min_val = min_q;
    assign count   = cnt_q;
    assign new_max = new_max_q;
    assign new_min = new_min_q;
    assign cmp_err = err_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//   Drives two trackers (CNT_W=8 and CNT_W=2) with identical stimulus, each
//   with its own behavioural comparator. Expected values come from a
//   transaction-level model: running max/min of accepted samples, a plain
//   sample counter clipped to each counter width, and a sticky error flag.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        bad;

    // Wide-counter instance
    logic        ready8, gt8, lt8, eq8, nmax8, nmin8, err8;
    logic [15:0] a8, b8, max8, min8;
    logic [7:0]  cnt8;

    // Narrow-counter instance
    logic        ready2, gt2, lt2, eq2, nmax2, nmin2, err2;
    logic [15:0] a2, b2, max2, min2;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    minmax_tracker #(.CNT_W(8)) u_dut8 (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(ready8), .cmp_a(a8), .cmp_b(b8),
        .cmp_gt(gt8), .cmp_lt(lt8), .cmp_eq(eq8),
        .max_val(max8), .min_val(min8), .count(cnt8),
        .new_max(nmax8), .new_min(nmin8), .cmp_err(err8)
    );

    minmax_tracker #(.CNT_W(2)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(ready2), .cmp_a(a2), .cmp_b(b2),
        .cmp_gt(gt2), .cmp_lt(lt2), .cmp_eq(eq2),
        .max_val(max2), .min_val(min2), .count(cnt2),
        .new_max(nmax2), .new_min(nmin2), .cmp_err(err2)
    );

    // Behavioural comparators; 'bad' forces a non-one-hot result.
    always_comb begin
        gt8 = (a8 > b8); lt8 = (a8 < b8); eq8 = (a8 == b8);
        gt2 = (a2 > b2); lt2 = (a2 < b2); eq2 = (a2 == b2);
        if (bad) begin
            gt8 = 1'b1; lt8 = 1'b1; eq8 = 1'b0;
            gt2 = 1'b1; lt2 = 1'b1; eq2 = 1'b0;
        end
    end

    // Scoreboard counters
    int n_vec = 0;
    int n_err = 0;

    // Reference model
    int unsigned mmax, mmin, mcnt;
    bit          merr;
    int          tot_acc = 0;
    int          acc_cnt = 0;
    time         last_acc = 0;
    bit          prev_hold = 0;
    bit          prev_first = 0;

    always @(posedge clk) if (sample_valid && ready8) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned clip(input int unsigned n, input int unsigned lim);
        return (n > lim) ? lim : n;
    endfunction

    task automatic model_reset();
        mmax = 0; mmin = 16'hFFFF; mcnt = 0; merr = 0;
        prev_hold = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".max"},  max8, mmax);
        chk({tag, ".min"},  min8, mmin);
        chk({tag, ".cnt8"}, cnt8, clip(mcnt, 255));
        chk({tag, ".err"},  err8, merr);
        chk({tag, ".max2"}, max2, mmax);
        chk({tag, ".min2"}, min2, mmin);
        chk({tag, ".cnt2"}, cnt2, clip(mcnt, 3));
        chk({tag, ".err2"}, err2, merr);
    endtask

    // Waits (bounded) for ready and returns at the acceptance edge.
    task automatic wait_accept(input logic [15:0] d, output bit ok);
        int n = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        #1;
        while (!ready8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = ready8;
        if (!ok) begin
            chk("ready_timeout", 0, 1);
            sample_valid = 1'b0;
            return;
        end
        @(posedge clk);
        tot_acc++;
    endtask

    // Full transaction with cycle-by-cycle checks. Starts/ends at a negedge.
    task automatic send(input logic [15:0] d, input bit hold, input bit bad_max);
        bit ok, first, en;
        wait_accept(d, ok);
        if (!ok) return;
        if (prev_hold) chk("spacing", 32'(($time - last_acc) / 10), prev_first ? 1 : 3);
        last_acc   = $time;
        first      = (mcnt == 0);
        prev_hold  = hold;
        prev_first = first;
        #1;
        if (!hold) sample_valid = 1'b0;
        if (bad_max && !first) bad = 1'b1;
        @(negedge clk);
        if (first) begin
            mmax = d; mmin = d; mcnt = 1;
            chk("first.new_max", nmax8, 1);
            chk("first.new_min", nmin8, 1);
            chk("first.ready", ready8, 1);
            check_state("first");
            return;
        end
        // CMP_MAX cycle
        chk("cmax.ready", ready8, 0);
        chk("cmax.a", a8, d);
        chk("cmax.b", b8, mmax);
        chk("cmax.new_max", nmax8, 0);
        chk("cmax.new_min", nmin8, 0);
        @(posedge clk);
        #1 bad = 1'b0;
        @(negedge clk);
        en = bad_max || (d > mmax);
        if (en) mmax = d;
        if (bad_max) merr = 1;
        // CMP_MIN cycle
        chk("cmin.max", max8, mmax);
        chk("cmin.new_max", nmax8, en);
        chk("cmin.ready", ready8, 0);
        chk("cmin.a", a8, d);
        chk("cmin.b", b8, mmin);
        chk("cmin.cnt", cnt8, clip(mcnt, 255));
        chk("cmin.err", err8, merr);
        @(negedge clk);
        en = (d < mmin);
        if (en) mmin = d;
        mcnt++;
        chk("done.new_min", nmin8, en);
        chk("done.new_max", nmax8, 0);
        chk("done.ready", ready8, 1);
        check_state("done");
    endtask

    task automatic do_clear(input bit with_valid);
        sample_valid = with_valid;
        sample_data  = 16'($urandom);
        clear        = 1'b1;
        #1;
        chk("clear.ready", ready8, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        model_reset();
        chk("clear.new_max", nmax8, 0);
        chk("clear.new_min", nmin8, 0);
        chk("clear.idle_ready", ready8, 1);
        check_state("clear");
    endtask

    // Clear asserted during CMP_MAX of an in-flight sample.
    task automatic send_clear(input logic [15:0] d);
        bit ok;
        wait_accept(d, ok);
        if (!ok) return;
        #1;
        sample_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        chk("cmaxclr.ready", ready8, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        model_reset();
        chk("cmaxclr.ready_after", ready8, 1);
        chk("cmaxclr.a", a8, 0);
        check_state("cmaxclr");
        repeat (3) @(negedge clk);
        check_state("cmaxclr.later");
        chk("cmaxclr.new_max", nmax8, 0);
    endtask

    // Reset dropped in the middle of CMP_MIN.
    task automatic send_reset(input logic [15:0] d);
        bit ok;
        wait_accept(d, ok);
        if (!ok) return;
        #1 sample_valid = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        model_reset();
        chk("arst.ready", ready8, 1);
        chk("arst.a", a8, 0);
        chk("arst.b", b8, 0);
        chk("arst.new_max", nmax8, 0);
        chk("arst.new_min", nmin8, 0);
        check_state("arst");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_state("arst.after");
    endtask

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample_data = '0; bad = 1'b0;
        model_reset();
        #12;
        chk("rst.ready", ready8, 1);
        chk("rst.a", a8, 0);
        chk("rst.b", b8, 0);
        chk("rst.new_max", nmax8, 0);
        chk("rst.new_min", nmin8, 0);
        check_state("rst");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Basic sequence, including an equal sample
        send(16'd100, 0, 0);
        send(16'd50,  0, 0);
        send(16'd200, 0, 0);
        send(16'd50,  0, 0);

        // Back-to-back stream with valid held high; saturates narrow counter
        do_clear(1);
        for (int unsigned i = 1; i <= 5; i++) send(16'(i), (i != 5), 0);

        // Boundary values
        do_clear(0);
        send(16'hFFFF, 0, 0);
        send(16'h0000, 0, 0);
        send(16'hFFFF, 0, 0);

        // Clear during CMP_MAX of the third sample
        do_clear(0);
        send(16'd10, 0, 0);
        send(16'd20, 0, 0);
        send_clear(16'd30);

        // Non-one-hot comparator result is sticky until clear
        send(16'd10, 0, 0);
        send(16'd20, 0, 1);
        send(16'd5,  0, 0);
        send(16'd7,  0, 0);
        do_clear(0);

        // Asynchronous reset mid-compare
        send(16'd40, 0, 0);
        send(16'd60, 0, 0);
        send_reset(16'd90);

        // Randomized traffic
        for (int unsigned i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: do_clear(1'($urandom_range(0, 1)));
                1: repeat ($urandom_range(1, 3)) @(negedge clk);
                default: send(rand_sample(), 0, 1'($urandom_range(0, 15) == 0));
            endcase
        end

        chk("accepts", acc_cnt, tot_acc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/minmax_tracker.md
# minmax_tracker

Sequential running-minimum/maximum tracker for 16-bit unsigned samples, built as the driving side of the team's 16-bit `comparator` interface. It accepts samples over a valid/ready handshake and drives the comparator's `a`/`b` operands. It consumes the comparator's `gt`/`lt`/`eq` results to maintain registered max, min and sample-count values. One shared comparator instance is time-multiplexed: two comparisons per sample. Sits between a sample source and the status/readout logic; the comparator is instantiated outside this block and wired to the `cmp_*` ports.

## Interface
- `CNT_W`, 8, width of the sample counter

- `clk`  in  1  system clock, all state updates on rising edge
- `n_rst`  in  1  reset, asynchronous, active-low
- `clear`  in  1  synchronous clear of all tracked state; priority over everything except `n_rst`
- `sample_valid`  in  1  `sample_data` is valid
- `sample_data`  in  16  unsigned sample
- `sample_ready`  out  1  block can accept a sample this cycle
- `cmp_a`  out  16  comparator operand a
- `cmp_b`  out  16  comparator operand b
- `cmp_gt` / `cmp_lt` / `cmp_eq`  in  1 each  comparator result for (`cmp_a`, `cmp_b`), combinational, same cycle
- `max_val`  out  16  largest sample seen
- `min_val`  out  16  smallest sample seen
- `count`  out  CNT_W  samples absorbed, saturating
- `new_max`  out  1  one-cycle pulse: `max_val` updated at previous edge
- `new_min`  out  1  one-cycle pulse: `min_val` updated at previous edge
- `cmp_err`  out  1  sticky: comparator flags were not one-hot during a compare state

## Operation
- Reset values: state IDLE, `max_val`=16'h0000, `min_val`=16'hFFFF, `count`=0, `new_max`=`new_min`=`cmp_err`=0, sample register 0.
- States: IDLE, CMP_MAX, CMP_MIN.
- IDLE:
  - `sample_ready` = !`clear`; `cmp_a`=`cmp_b`=0; comparator flags ignored.
  - On `sample_valid` && `sample_ready`, if `count`==0: load `max_val`=`min_val`=`sample_data`, pulse both `new_max` and `new_min`, set `count`=1, stay IDLE (no comparisons).
  - On `sample_valid` && `sample_ready`, otherwise: latch `sample_data` into the sample register and go to CMP_MAX.
- CMP_MAX:
  - `cmp_a`=sample register, `cmp_b`=`max_val`, `sample_ready`=0.
  - If `cmp_gt`, load `max_val` and pulse `new_max`.
  - Always go to CMP_MIN.
- CMP_MIN:
  - `cmp_a`=sample register, `cmp_b`=`min_val`, `sample_ready`=0.
  - If `cmp_lt`, load `min_val` and pulse `new_min`.
  - Increment `count`, saturating at 2^CNT_W−1.
  - Go to IDLE.
- Equal samples (`cmp_eq`): no update and no pulse; count still increments.
- `cmp_err`: set in CMP_MAX/CMP_MIN when (`cmp_gt`+`cmp_lt`+`cmp_eq`) != 1. Cleared only by `clear` or reset. Updates still follow `cmp_gt`/`cmp_lt` as given.
- `clear`:
  - Returns all state to the reset values on the next edge, from any state.
  - An in-flight sample is discarded and not counted.
  - No sample is accepted in a `clear` cycle.
- All comparisons are unsigned, matching the comparator.

## Timing
- Sample accepted at edge k, first sample (`count`==0): `max_val`/`min_val`/`count` valid after edge k; pulses high for cycle k..k+1.
- Sample accepted at edge k, otherwise:
  - CMP_MAX occupies cycle k..k+1; `max_val` and `new_max` change at edge k+1.
  - CMP_MIN occupies cycle k+1..k+2; `min_val`, `new_min` and `count` change at edge k+2.
  - `sample_ready` is high again in cycle k+2..k+3.
- Throughput: 1 sample per 3 cycles (steady state), 1 per cycle only while `count`==0.
- `new_max`/`new_min` are registered and deassert the cycle after assertion unless re-asserted.
- `n_rst` mid-operation: immediate asynchronous return to reset values; partial sample discarded.
- Outputs `cmp_a`/`cmp_b`/`sample_ready` are combinational from state and registers only; there is no combinational path from `sample_data` to `cmp_*`.

## Test plan
- Reset then samples 100, 50, 200, 50 with a correct comparator → `max_val`=200, `min_val`=50, `count`=4; `new_max` pulses on 100 and 200 only; `new_min` pulses on 100 and the first 50 only; `cmp_err`=0.
- `sample_valid` held high continuously after the first sample → `sample_ready` pattern 1,0,0 repeating; exactly one sample accepted per 3 cycles; `max_val` update at acceptance+1, `min_val`/`count` at acceptance+2.
- CNT_W=2, feed 5 samples 1..5 → `count` sticks at 3; `max_val`=5, `min_val`=1.
- Boundary values 16'hFFFF then 16'h0000 then 16'hFFFF → `max_val`=16'hFFFF, `min_val`=16'h0000; third sample `cmp_eq` in CMP_MAX gives no `new_max`.
- Assert `clear` during CMP_MAX of the 3rd sample → next cycle IDLE with `count`=0, `max_val`=0, `min_val`=16'hFFFF; the in-flight sample never appears; `sample_ready`=0 during the `clear` cycle.
- Force `cmp_gt`=`cmp_lt`=1 in CMP_MAX → `cmp_err`=1 and stays 1 across later samples until `clear`; drop `n_rst` mid-CMP_MIN → all outputs at reset values immediately, before the next clock edge.
